bus_mem_responder: RTL and testbench
====================================

Name: bus_mem_responder

Overview:
- Memory-side responder for the CPU external bus. Consumes the CPU's o_ad/o_tag/o_astb/o_rd/o_wr and returns i_data/i_tag.
- Holds a 72-bit word store (64 data + 8 tag) addressed by a 20-bit word address.
- Serves reads with a fixed, parameterised latency and supports auto-incrementing bursts.
- Used as the memory model in CPU-level benches and as the reference responder for bus bring-up.

Parameters:
AW, 20, word address width taken from o_ad[AW-1:0]; store depth 2**AW
RD_LAT, 2, cycles from rd-sample edge to i_data valid; legal 1..8

Ports:
clk  in  1  clock; all state on posedge
reset  in  1  asynchronous, active-low reset (0 = reset asserted)
o_ad  in  64  address (astb cycle) or write data (wr cycle) from CPU
o_tag  in  8  write tag from CPU
o_astb  in  1  address strobe
o_rd  in  1  read request
o_wr  in  1  write request
i_data  out  64  read data to CPU
i_tag  out  8  read tag to CPU
rd_valid  out  1  one-cycle pulse: i_data/i_tag updated with a new read result this cycle
err  out  1  sticky protocol-error flag

Behaviour:
- Reset (reset=0, async):
  - state=IDLE, addr_q=0, all pipeline valids=0.
  - i_data=0, i_tag=0, rd_valid=0, err=0.
  - Store contents are NOT reset; benches preload the store by hierarchical assignment.
- States: IDLE (no address held), ARMED (addr_q valid).
- Address latch:
  - posedge with astb=1, rd=0, wr=0: addr_q<=o_ad[AW-1:0]; state<=ARMED.
  - Applies from either state; the last strobe wins. o_ad[63:AW] is ignored.
- ARMED, wr=1, rd=0, astb=0:
  - mem[addr_q]<={o_tag,o_ad} at this edge.
  - addr_q<=addr_q+1 mod 2**AW; stay ARMED.
- ARMED, rd=1, wr=0, astb=0:
  - Sample mem[addr_q] at this edge (value as of before this edge) into pipeline stage 1.
  - addr_q<=addr_q+1 mod 2**AW; stay ARMED.
- ARMED, no request: hold addr_q indefinitely.
- Read pipeline:
  - RD_LAT stages of {valid,tag,data}; sample edge = edge 0.
  - At edge RD_LAT: i_data/i_tag<=result, rd_valid=1 for exactly that cycle.
  - i_data/i_tag hold the last result otherwise; they are never cleared except by reset.
  - Throughput: one read per cycle; back-to-back reads give contiguous rd_valid pulses.
- Read-after-write: a write at edge N is visible to a read sampled at edge N+1 or later.
- Errors (err<=1, sticky until reset; the offending cycle performs no access, no address change, no state change):
  - rd=1 and wr=1 together.
  - astb=1 together with rd or wr.
  - rd or wr while in IDLE.
- Reads already in flight when an error occurs complete normally.
- Wrap: address 2**AW-1 increments to 0 without error.
- Reset mid-operation: in-flight reads are discarded; no rd_valid follows release; state returns to IDLE, so a new astb is required.

Test Plan:
1. Write/read round trip, RD_LAT=2:
   - Stimulus: astb ad=0x123; wr ad=0x0123456789ABCDEF tag=0x5A; astb ad=0x123; rd.
   - Required: rd_valid high exactly 2 edges after the rd edge; i_data=0x0123456789ABCDEF, i_tag=0x5A; values held afterwards.
2. Burst:
   - Stimulus: astb 0x10; wr x4 back-to-back, data 1,2,3,4 tags 0xA0..0xA3; astb 0x10; rd x4 back-to-back.
   - Required: rd_valid high 4 consecutive cycles; data 1,2,3,4 with tags 0xA0..0xA3 in order.
3. Wrap:
   - Stimulus: astb 0xFFFFF; wr 0xAA; wr 0xBB; astb 0; rd.
   - Required: i_data=0xBB; mem[0xFFFFF]=0xAA; err stays 0.
4. Protocol errors:
   - Stimulus: rd right after reset release (IDLE).
   - Required: err=1, no rd_valid, i_data=0.
   - Stimulus: then astb with wr=1 in the same cycle.
   - Required: no write; addr_q unchanged; err stays 1 until reset.
5. Reset mid-read:
   - Stimulus: rd issued; reset=0 the next cycle for 1 cycle.
   - Required: outputs 0 immediately (async); no rd_valid after release; a following rd without astb sets err.
6. Latency variant: repeat scenario 1 with RD_LAT=1 and RD_LAT=8 -> rd_valid exactly 1 and 8 edges after the rd edge, respectively.

Source files
------------

// File: rtl/bus_mem_responder.sv
// Memory-side responder for the CPU external bus: 72-bit word store with
// strobed address latch, auto-incrementing read/write bursts and fixed read latency.
//
// state | meaning
// IDLE  | no address held; rd/wr are protocol errors
// ARMED | addr_q valid; rd/wr access it and post-increment
module bus_mem_responder #(
  parameter int AW     = 20,
  parameter int RD_LAT = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [63:0] o_ad,
  input  logic [7:0]  o_tag,
  input  logic        o_astb,
  input  logic        o_rd,
  input  logic        o_wr,
  output logic [63:0] i_data,
  output logic [7:0]  i_tag,
  output logic        rd_valid,
  output logic        err
);

  typedef enum logic {IDLE, ARMED} state_t;

  logic [71:0]   mem_q [2**AW];
  logic [71:0]   pd_q  [RD_LAT];
  logic [RD_LAT-1:0] pv_q;

  state_t        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          err_q, err_d;
  logic          wr_en, rd_en, proto_err;
  logic [71:0]   out_q;
  logic          rd_valid_q;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    err_d     = err_q;
    wr_en     = 1'b0;
    rd_en     = 1'b0;
    proto_err = (o_rd && o_wr) || (o_astb && (o_rd || o_wr)) ||
                ((o_rd || o_wr) && (state_q == IDLE));
    // An offending cycle only raises err; nothing else moves.
    if (proto_err) begin
      err_d = 1'b1;
    end else if (o_astb) begin
      addr_d  = o_ad[AW-1:0];
      state_d = ARMED;
    end else if (o_wr) begin
      wr_en  = 1'b1;
      addr_d = addr_q + AW'(1);
    end else if (o_rd) begin
      rd_en  = 1'b1;
      addr_d = addr_q + AW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      err_q      <= 1'b0;
      pv_q       <= '0;
      out_q      <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      err_q      <= err_d;
      pv_q[0]    <= rd_en;
      for (int i = 1; i < RD_LAT; i++) pv_q[i] <= pv_q[i-1];
      rd_valid_q <= pv_q[RD_LAT-1];
      if (pv_q[RD_LAT-1]) out_q <= pd_q[RD_LAT-1];
    end
  end

  // Store and pipeline payload carry no reset so the array maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[addr_q] <= {o_tag, o_ad};
    if (rd_en) pd_q[0] <= mem_q[addr_q];
    for (int i = 1; i < RD_LAT; i++) pd_q[i] <= pd_q[i-1];
  end

  assign i_data   = out_q[63:0];
  assign i_tag    = out_q[71:64];
  assign rd_valid = rd_valid_q;
  assign err      = err_q;

endmodule

// File: tb/tb_bus_mem_responder.sv
// Directed bench for bus_mem_responder: table-driven main sequence on the
// RD_LAT=2 instance, hand sequences for reset, protocol errors and latency variants.
module tb_bus_mem_responder;

  logic        clk, rst_n;
  logic [63:0] o_ad;
  logic [7:0]  o_tag;
  logic        o_astb, o_rd, o_wr;
  logic [63:0] d1, d2, d8;
  logic [7:0]  t1, t2, t8;
  logic        v1, v2, v8, e1, e2, e8;

  int n_cmp  = 0;
  int n_fail = 0;

  bus_mem_responder #(.AW(20), .RD_LAT(1)) u_lat1 (
    .clk(clk), .reset(rst_n), .o_ad(o_ad), .o_tag(o_tag), .o_astb(o_astb),
    .o_rd(o_rd), .o_wr(o_wr), .i_data(d1), .i_tag(t1), .rd_valid(v1), .err(e1));
  bus_mem_responder #(.AW(20), .RD_LAT(2)) u_lat2 (
    .clk(clk), .reset(rst_n), .o_ad(o_ad), .o_tag(o_tag), .o_astb(o_astb),
    .o_rd(o_rd), .o_wr(o_wr), .i_data(d2), .i_tag(t2), .rd_valid(v2), .err(e2));
  bus_mem_responder #(.AW(20), .RD_LAT(8)) u_lat8 (
    .clk(clk), .reset(rst_n), .o_ad(o_ad), .o_tag(o_tag), .o_astb(o_astb),
    .o_rd(o_rd), .o_wr(o_wr), .i_data(d8), .i_tag(t8), .rd_valid(v8), .err(e8));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        astb, rd, wr;
    logic [63:0] ad;
    logic [7:0]  tag;
    logic        exp_v;
    logic [63:0] exp_d;
    logic [7:0]  exp_t;
    logic        exp_e;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic a, logic r, logic w, logic [63:0] ad, logic [7:0] tg,
                              logic ev, logic [63:0] ed, logic [7:0] et);
    vec_t v;
    v.astb = a; v.rd = r; v.wr = w; v.ad = ad; v.tag = tg;
    v.exp_v = ev; v.exp_d = ed; v.exp_t = et; v.exp_e = 1'b0;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [71:0] act, input logic [71:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic a, input logic r, input logic w,
                       input logic [63:0] ad, input logic [7:0] tg);
    o_astb = a; o_rd = r; o_wr = w; o_ad = ad; o_tag = tg;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive(0, 0, 0, 64'h0, 8'h0);
    step();
    step();
    rst_n = 1'b1;
  endtask

  localparam logic [63:0] D1 = 64'h0123456789ABCDEF;
  localparam logic [63:0] D2 = 64'h0F1E2D3C4B5A6978;

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int nv;
    int lat1, lat2, lat8, np1, np2, np8;
    rst_n = 1'b0;
    drive(0, 0, 0, 64'h0, 8'h0);
    #2;
    chk("reset_data", {t2, d2}, 72'h0);
    chk("reset_valid_err", {v2, e2}, 2'b00);
    step();
    step();
    rst_n = 1'b1;

    // round trip
    vecs.push_back(mk(1,0,0, 64'h123, 8'h00, 0, 64'h0, 8'h00));
    vecs.push_back(mk(0,0,1, D1,      8'h5A, 0, 64'h0, 8'h00));
    vecs.push_back(mk(1,0,0, 64'h123, 8'h00, 0, 64'h0, 8'h00));
    vecs.push_back(mk(0,1,0, 64'h0,   8'h00, 0, 64'h0, 8'h00));
    vecs.push_back(mk(0,0,0, 64'h0,   8'h00, 0, 64'h0, 8'h00));
    vecs.push_back(mk(0,0,0, 64'h0,   8'h00, 1, D1,    8'h5A));
    vecs.push_back(mk(0,0,0, 64'h0,   8'h00, 0, D1,    8'h5A));
    vecs.push_back(mk(0,0,0, 64'h0,   8'h00, 0, D1,    8'h5A));
    // burst
    vecs.push_back(mk(1,0,0, 64'h10,  8'h00, 0, D1,    8'h5A));
    vecs.push_back(mk(0,0,1, 64'h1,   8'hA0, 0, D1,    8'h5A));
    vecs.push_back(mk(0,0,1, 64'h2,   8'hA1, 0, D1,    8'h5A));
    vecs.push_back(mk(0,0,1, 64'h3,   8'hA2, 0, D1,    8'h5A));
    vecs.push_back(mk(0,0,1, 64'h4,   8'hA3, 0, D1,    8'h5A));
    vecs.push_back(mk(1,0,0, 64'hDEADBEEF00000010, 8'h00, 0, D1, 8'h5A));
    vecs.push_back(mk(0,1,0, 64'h0,   8'h00, 0, D1,    8'h5A));
    vecs.push_back(mk(0,1,0, 64'h0,   8'h00, 0, D1,    8'h5A));
    vecs.push_back(mk(0,1,0, 64'h0,   8'h00, 1, 64'h1, 8'hA0));
    vecs.push_back(mk(0,1,0, 64'h0,   8'h00, 1, 64'h2, 8'hA1));
    vecs.push_back(mk(0,0,0, 64'h0,   8'h00, 1, 64'h3, 8'hA2));
    vecs.push_back(mk(0,0,0, 64'h0,   8'h00, 1, 64'h4, 8'hA3));
    vecs.push_back(mk(0,0,0, 64'h0,   8'h00, 0, 64'h4, 8'hA3));
    // wrap
    vecs.push_back(mk(1,0,0, 64'hFFFFF, 8'h00, 0, 64'h4, 8'hA3));
    vecs.push_back(mk(0,0,1, 64'hAA,  8'h11, 0, 64'h4, 8'hA3));
    vecs.push_back(mk(0,0,1, 64'hBB,  8'h22, 0, 64'h4, 8'hA3));
    vecs.push_back(mk(1,0,0, 64'h0,   8'h00, 0, 64'h4, 8'hA3));
    vecs.push_back(mk(0,1,0, 64'h0,   8'h00, 0, 64'h4, 8'hA3));
    vecs.push_back(mk(0,0,0, 64'h0,   8'h00, 0, 64'h4, 8'hA3));
    vecs.push_back(mk(0,0,0, 64'h0,   8'h00, 1, 64'hBB, 8'h22));
    vecs.push_back(mk(0,0,0, 64'h0,   8'h00, 0, 64'hBB, 8'h22));

    nv = vecs.size();
    for (int i = 0; i < nv; i++) begin
      drive(vecs[i].astb, vecs[i].rd, vecs[i].wr, vecs[i].ad, vecs[i].tag);
      step();
      chk($sformatf("vec%0d_valid", i), v2, vecs[i].exp_v);
      chk($sformatf("vec%0d_data", i), d2, vecs[i].exp_d);
      chk($sformatf("vec%0d_tag", i), t2, vecs[i].exp_t);
      chk($sformatf("vec%0d_err", i), e2, vecs[i].exp_e);
    end
    chk("wrap_mem_top", u_lat2.mem_q[20'hFFFFF], {8'h11, 64'hAA});
    chk("wrap_mem_zero", u_lat2.mem_q[20'h0], {8'h22, 64'hBB});
    chk("wrap_addr_after_rd", 72'(u_lat2.addr_q), 72'h1);

    // reset mid-read
    drive(1, 0, 0, 64'h10, 8'h0);
    step();
    drive(0, 1, 0, 64'h0, 8'h0);
    step();
    drive(0, 0, 0, 64'h0, 8'h0);
    rst_n = 1'b0;
    #1;
    chk("midrst_out2", {t2, d2, v2, e2}, 74'h0);
    chk("midrst_out8", {t8, d8, v8, e8}, 74'h0);
    step();
    rst_n = 1'b1;
    np1 = 0;
    for (int k = 0; k < 12; k++) begin
      step();
      if (v1 || v2 || v8) np1++;
    end
    chk("midrst_no_valid", 72'(np1), 72'h0);
    drive(0, 1, 0, 64'h0, 8'h0);
    step();
    drive(0, 0, 0, 64'h0, 8'h0);
    chk("midrst_rd_idle_err", {e1, e2, e8}, 3'b111);
    np1 = 0;
    for (int k = 0; k < 10; k++) begin
      step();
      if (v1 || v2 || v8) np1++;
    end
    chk("midrst_err_no_read", 72'(np1), 72'h0);

    // protocol errors from IDLE
    do_reset();
    u_lat2.mem_q[20'h0]   = {8'h77, 64'h7777};
    u_lat2.mem_q[20'h200] = {8'h66, 64'h6666};
    chk("err_cleared_by_reset", e2, 1'b0);
    drive(0, 1, 0, 64'h0, 8'h0);
    step();
    drive(0, 0, 0, 64'h0, 8'h0);
    chk("idle_rd_err", e2, 1'b1);
    np2 = 0;
    for (int k = 0; k < 4; k++) begin
      if (v2) np2++;
      step();
    end
    chk("idle_rd_no_valid", 72'(np2), 72'h0);
    chk("idle_rd_data", {t2, d2}, 72'h0);
    drive(1, 0, 1, 64'h200, 8'h55);
    step();
    drive(0, 0, 0, 64'h0, 8'h0);
    chk("astb_wr_addr", 72'(u_lat2.addr_q), 72'h0);
    chk("astb_wr_mem0", u_lat2.mem_q[20'h0], {8'h77, 64'h7777});
    chk("astb_wr_mem200", u_lat2.mem_q[20'h200], {8'h66, 64'h6666});
    drive(1, 0, 0, 64'h300, 8'h0);
    step();
    drive(0, 0, 0, 64'h0, 8'h0);
    chk("err_sticky", e2, 1'b1);
    chk("astb_after_err", 72'(u_lat2.addr_q), 72'h300);
    drive(1, 1, 0, 64'h5, 8'h0);
    step();
    drive(0, 0, 0, 64'h0, 8'h0);
    chk("astb_rd_addr", 72'(u_lat2.addr_q), 72'h300);

    // latency variants
    do_reset();
    drive(1, 0, 0, 64'h123, 8'h0);  step();
    drive(0, 0, 1, D2, 8'h3C);      step();
    drive(1, 0, 0, 64'h123, 8'h0);  step();
    drive(0, 1, 0, 64'h0, 8'h0);    step();
    drive(0, 0, 0, 64'h0, 8'h0);
    lat1 = -1; lat2 = -1; lat8 = -1; np1 = 0; np2 = 0; np8 = 0;
    for (int k = 1; k <= 12; k++) begin
      step();
      if (v1) begin if (lat1 < 0) lat1 = k; np1++; end
      if (v2) begin if (lat2 < 0) lat2 = k; np2++; end
      if (v8) begin if (lat8 < 0) lat8 = k; np8++; end
    end
    chk("lat1_edges", 72'(lat1), 72'd1);
    chk("lat2_edges", 72'(lat2), 72'd2);
    chk("lat8_edges", 72'(lat8), 72'd8);
    chk("lat_pulse_counts", {24'(np1), 24'(np2), 24'(np8)}, {24'd1, 24'd1, 24'd1});
    chk("lat1_data", {t1, d1}, {8'h3C, D2});
    chk("lat2_data", {t2, d2}, {8'h3C, D2});
    chk("lat8_data", {t8, d8}, {8'h3C, D2});
    chk("lat_err", {e1, e2, e8}, 3'b000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
